regfile_mul_unit: RTL
=====================

Name: regfile_mul_unit

Overview:
- Iterative shift-add 32x32 multiplier.
- Sits directly downstream of the register file read ports and upstream of its write port:
  - consumes the two read operands;
  - writes the 64-bit product back through the file's single write port (WriteEn/WriteAddr/In).
- Low word goes to DestAddr. If requested, the high word goes to DestAddr+1 (mod 32) in the following cycle.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH.
- ADDR_W, 5, register address width.

Ports:
- Clk, input, 1, rising-edge clock.
- Rst, input, 1, asynchronous active-high reset.
- Start, input, 1, request; sampled only in IDLE.
- Signed, input, 1, 1 = two's-complement operands; 0 = unsigned. Sampled with Start.
- WriteHi, input, 1, also write the high word to DestAddr+1. Sampled with Start.
- OpA, input, WIDTH, multiplicand, from register file OutA.
- OpB, input, WIDTH, multiplier, from register file OutB.
- DestAddr, input, ADDR_W, destination register. Sampled with Start.
- Busy, output, 1, operation in progress.
- Done, output, 1, one-cycle pulse during the final write-back cycle.
- RfWriteEn, output, 1, drives register file WriteEn.
- RfWriteAddr, output, ADDR_W, drives WriteAddr.
- RfWriteData, output, WIDTH, drives register file In.
- ProductHi, output, WIDTH, last completed product, high word.
- ProductLo, output, WIDTH, last completed product, low word.

Behaviour:
- Clock and reset: one clock domain, Clk. Rst is asynchronous, active-high.
- Reset values:
  - all outputs 0;
  - FSM in IDLE;
  - internal accumulator, counter and latched fields cleared.
- Reset mid-operation: abort immediately, no write issued, product registers cleared.
- FSM states: IDLE, CALC, WB_LO, WB_HI.
- IDLE:
  - Busy=0.
  - On a Clk edge with Start=1: latch Signed, WriteHi and DestAddr.
  - Latch |OpA| and |OpB| when Signed=1, raw values otherwise.
  - Record the result sign as OpA[WIDTH-1]^OpB[WIDTH-1] when Signed, 0 otherwise.
  - Clear the 2*WIDTH accumulator and the counter; go to CALC.
- CALC:
  - Busy=1. One multiplier bit per cycle, LSB first.
  - If the current bit is 1, add the multiplicand to the accumulator upper half with carry. Then shift right by 1.
  - Counter runs 0..WIDTH-1. After WIDTH iterations go to WB_LO.
  - Load ProductHi/ProductLo with the final value, two's-complement negated over 2*WIDTH if the sign flag is set.
- Magnitude rule: magnitude of 0x80000000 is 0x80000000 as unsigned. No overflow is possible in 2*WIDTH bits.
- WB_LO:
  - RfWriteEn=1, RfWriteAddr=DestAddr, RfWriteData=ProductLo.
  - If WriteHi, go to WB_HI. Otherwise Done=1 this cycle and go to IDLE.
- WB_HI:
  - RfWriteEn=1, RfWriteAddr=DestAddr+1 (wraps: 31 -> 0), RfWriteData=ProductHi.
  - Done=1; go to IDLE.
- Latency: RfWriteEn first asserts exactly WIDTH+1 edges after the edge that sampled Start, i.e. 33 for WIDTH=32.
- Throughput: the next Start is accepted on the edge that returns the FSM to IDLE at the earliest. Start while Busy=1, including the Done cycle, is ignored and not queued.
- Output timing:
  - Done, RfWriteEn, RfWriteAddr and RfWriteData are registered or state-decoded; no glitch-free guarantee is needed.
  - RfWriteEn, RfWriteAddr and RfWriteData are 0 in all states other than WB_LO/WB_HI.
- Product registers: ProductHi/ProductLo hold their value until the next completion or reset.
- Operand stability: OpA/OpB need only be valid in the Start cycle. Later register file updates do not affect the result.
- DestAddr=0: the write is issued normally. Register-0 semantics belong to the register file.

Test Plan:
- Reset then unsigned multiply:
  - Stimulus: Rst pulse, then Start with Signed=0, WriteHi=0, OpA=7, OpB=6, DestAddr=3.
  - Required: 33 edges later RfWriteEn=1, RfWriteAddr=3, RfWriteData=42 with Done=1 for exactly one cycle. Busy drops next cycle; ProductHi=0.
- Signed multiply with high-word write:
  - Stimulus: Signed=1, WriteHi=1, OpA=0xFFFFFFFD (-3), OpB=5, DestAddr=5.
  - Required: write addr 5 data 0xFFFFFFF1, next cycle addr 6 data 0xFFFFFFFF with Done=1.
- Unsigned maximum with address wrap:
  - Stimulus: Signed=0, WriteHi=1, OpA=OpB=0xFFFFFFFF, DestAddr=31.
  - Required: addr 31 data 0x00000001, then addr 0 data 0xFFFFFFFE.
- Signed most-negative operands:
  - Stimulus: Signed=1, OpA=OpB=0x80000000.
  - Required: ProductHi=0x40000000, ProductLo=0x00000000.
- Start ignored while busy:
  - Stimulus: Start asserted during CALC cycle 5 with OpA=9, and again in the Done cycle.
  - Required: the first result is unaffected, no extra write occurs, and Busy=0 after the write.
- Reset mid-operation:
  - Stimulus: Rst asserted asynchronously mid-cycle during CALC iteration 10.
  - Required: outputs go 0 immediately, no RfWriteEn ever asserts for that operation, and a fresh Start afterwards completes normally with the correct product.

Source files
------------

// File: rtl/regfile_mul_unit.sv
// rtl/regfile_mul_unit.sv - iterative shift-add multiplier writing its product back through the register file write port
module regfile_mul_unit #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic              Signed,
    input  logic              WriteHi,
    input  logic [WIDTH-1:0]  OpA,
    input  logic [WIDTH-1:0]  OpB,
    input  logic [ADDR_W-1:0] DestAddr,
    output logic              Busy,
    output logic              Done,
    output logic              RfWriteEn,
    output logic [ADDR_W-1:0] RfWriteAddr,
    output logic [WIDTH-1:0]  RfWriteData,
    output logic [WIDTH-1:0]  ProductHi,
    output logic [WIDTH-1:0]  ProductLo
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        WB_LO,
        WB_HI
    } state_t;

    state_t              state;
    logic [WIDTH-1:0]    mcand;
    logic [WIDTH-1:0]    mplier;
    logic [2*WIDTH-1:0]  acc;
    logic [CNT_W-1:0]    count;
    logic                iter_done;
    logic                neg;
    logic                write_hi;
    logic [ADDR_W-1:0]   dest;

    logic [WIDTH-1:0]    abs_a;
    logic [WIDTH-1:0]    abs_b;
    logic [WIDTH-1:0]    addend;
    logic [WIDTH:0]      sum;
    logic [2*WIDTH-1:0]  acc_next;
    logic [2*WIDTH-1:0]  final_prod;

    // Operand magnitudes; the most negative value maps onto itself, which is
    // already the correct magnitude when read as unsigned.
    always_comb begin
        abs_a = OpA;
        abs_b = OpB;
        if (Signed && OpA[WIDTH-1]) begin
            abs_a = -OpA;
        end
        if (Signed && OpB[WIDTH-1]) begin
            abs_b = -OpB;
        end
    end

    // One shift-add step: conditionally add the multiplicand into the upper
    // half, keep the carry, and shift the whole accumulator right by one.
    always_comb begin
        addend   = mplier[count] ? mcand : '0;
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        acc_next = {sum, acc[WIDTH-1:1]};
    end

    // Sign correction of the magnitude product.
    always_comb begin
        final_prod = acc;
        if (neg) begin
            final_prod = -acc;
        end
    end

    // Control FSM with registered write-port outputs. CALC spends WIDTH
    // cycles iterating plus one cycle applying the sign and loading the
    // product registers, so the first write lands WIDTH+1 edges after Start.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state       <= IDLE;
            mcand       <= '0;
            mplier      <= '0;
            acc         <= '0;
            count       <= '0;
            iter_done   <= 1'b0;
            neg         <= 1'b0;
            write_hi    <= 1'b0;
            dest        <= '0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            RfWriteEn   <= 1'b0;
            RfWriteAddr <= '0;
            RfWriteData <= '0;
            ProductHi   <= '0;
            ProductLo   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    Done        <= 1'b0;
                    RfWriteEn   <= 1'b0;
                    RfWriteAddr <= '0;
                    RfWriteData <= '0;
                    if (Start) begin
                        mcand     <= abs_a;
                        mplier    <= abs_b;
                        neg       <= Signed & (OpA[WIDTH-1] ^ OpB[WIDTH-1]);
                        write_hi  <= WriteHi;
                        dest      <= DestAddr;
                        acc       <= '0;
                        count     <= '0;
                        iter_done <= 1'b0;
                        Busy      <= 1'b1;
                        state     <= CALC;
                    end
                end

                CALC: begin
                    if (!iter_done) begin
                        acc   <= acc_next;
                        count <= count + 1'b1;
                        if (count == LAST_BIT) begin
                            iter_done <= 1'b1;
                        end
                    end else begin
                        ProductHi   <= final_prod[2*WIDTH-1:WIDTH];
                        ProductLo   <= final_prod[WIDTH-1:0];
                        RfWriteEn   <= 1'b1;
                        RfWriteAddr <= dest;
                        RfWriteData <= final_prod[WIDTH-1:0];
                        Done        <= ~write_hi;
                        state       <= WB_LO;
                    end
                end

                WB_LO: begin
                    if (write_hi) begin
                        RfWriteEn   <= 1'b1;
                        RfWriteAddr <= dest + 1'b1;
                        RfWriteData <= ProductHi;
                        Done        <= 1'b1;
                        state       <= WB_HI;
                    end else begin
                        RfWriteEn   <= 1'b0;
                        RfWriteAddr <= '0;
                        RfWriteData <= '0;
                        Done        <= 1'b0;
                        Busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end

                WB_HI: begin
                    RfWriteEn   <= 1'b0;
                    RfWriteAddr <= '0;
                    RfWriteData <= '0;
                    Done        <= 1'b0;
                    Busy        <= 1'b0;
                    state       <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
